config_chain_loader: RTL and testbench
======================================

Name: config_chain_loader

Overview:
- Programming-side controller that feeds the fabric configuration chain (ccff chain) of the FPGA core in the PMU.
- Accepts bitstream words over a valid/ready interface and serializes them LSB-first onto the chain head, one bit per prog_clk with a shift enable.
- Counts bits to the chain length and holds the chain head at logic 0 (const0 tie-off level) whenever it is not shifting.

Parameters:
- WORD_W, 32, input word width in bits, ≥2.
- CHAIN_LEN, 1024, total configuration-chain length in bits, ≥1.
- CNT_W, $clog2(CHAIN_LEN+1), bit-counter width. Derived; do not override.

Ports:
- prog_clk  input  1  programming clock; all state changes on its rising edge.
- pReset  input  1  reset; synchronous, active-high.
- start  input  1  begin a programming pass; sampled in IDLE or DONE only.
- abort  input  1  cancel the current pass; returns to IDLE.
- s_data  input  WORD_W  bitstream word; bit 0 is shifted first.
- s_valid  input  1  s_data valid.
- s_ready  output  1  loader accepts a word this cycle.
- ccff_head  output  1  serial data into the chain head.
- ccff_shift_en  output  1  chain shift enable; the chain samples ccff_head when this is 1.
- busy  output  1  pass in progress (LOAD or SHIFT).
- done  output  1  full chain written; held until next start, abort or reset.
- aborted  output  1  one-cycle pulse after an abort of an active pass.

Behaviour:
- Reset, and pReset asserted mid-pass:
  - Next edge: state=IDLE; s_ready, ccff_head, ccff_shift_en, busy, done, aborted = 0.
  - Bit counter and shift register = 0.
  - Reset overrides start and abort.
- States: IDLE, LOAD, SHIFT, DONE. All outputs are decoded from registered state/datapath only, with no input-to-output combinational paths, except s_ready = (state==LOAD).
- IDLE:
  - start=1 → LOAD; clear bit_cnt and done.
- LOAD:
  - s_ready=1.
  - s_valid=1 → capture s_data into sreg, set word_left = min(WORD_W, CHAIN_LEN−bit_cnt), go to SHIFT.
  - s_valid=0 → stay in LOAD indefinitely. This is the starvation case; no timeout.
- SHIFT:
  - ccff_shift_en=1 and ccff_head=sreg[0] every cycle.
  - Each edge: sreg shifts right with zero fill; bit_cnt+1; word_left−1.
  - When word_left==1: if bit_cnt+1==CHAIN_LEN → DONE, else → LOAD.
  - Bits of a final word beyond CHAIN_LEN are discarded and never shifted.
- DONE:
  - done=1, busy=0.
  - start=1 → LOAD with bit_cnt cleared and done cleared the same edge.
  - abort in DONE → IDLE, done cleared, no aborted pulse.
- Outside SHIFT: ccff_shift_en=0 and ccff_head=0.
- busy = (state==LOAD || state==SHIFT).
- start while busy is ignored.
- abort:
  - In LOAD or SHIFT, abort has priority over every other transition, including word acceptance and the final shift.
  - Next edge: state=IDLE; ccff_shift_en=0; aborted=1 for exactly one cycle; done=0.
  - The partially shifted chain contents are left as-is.
  - A word presented together with abort is not accepted (s_ready is 1, but the loader treats abort as winning and drops the word). Upstream must not count it as consumed: effective handshake = s_valid & s_ready & ~abort.
- Latency and throughput:
  - start at edge n → s_ready=1 in cycle n+1.
  - Word accepted at edge m → first ccff_shift_en=1 in cycle m+1.
  - Each word costs 1 LOAD cycle + word_left SHIFT cycles; there is no prefetch.
  - Total with s_valid held 1 = ceil(CHAIN_LEN/WORD_W) + CHAIN_LEN cycles from first LOAD to DONE. Default parameters: 32 + 1024 = 1056.
- Width rules:
  - bit_cnt never exceeds CHAIN_LEN.
  - word_left is sized $clog2(WORD_W+1).
  - CHAIN_LEN < WORD_W is legal: a single partial word.

Test Plan (WORD_W=8, CHAIN_LEN=20 unless noted):
- Reset then idle: hold pReset 2 cycles, release → all outputs 0. 10 idle cycles → ccff_head=0 and ccff_shift_en=0 throughout.
- Basic pass: start; words 0xA5, 0x3C, 0xFF with s_valid always 1.
  - ccff_head sequence on shift_en cycles = 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1. That is 20 bits; the upper 4 bits of 0xFF are dropped.
  - done=1 exactly 23 cycles after the first LOAD cycle; s_ready asserted 3 times total.
- Backpressure: s_valid low for 5 cycles in each LOAD → s_ready held 1, no shift_en pulses while waiting, same 20-bit sequence, done asserted.
- Abort mid-shift: abort on the 4th SHIFT cycle of word 2 → next cycle IDLE, shift_en=0, aborted pulse of width 1, done=0. New start then completes a full 20-bit pass.
- Abort colliding with s_valid in LOAD → word not consumed, aborted=1. Reset mid-SHIFT → all outputs 0 next edge.
- Edge parameters: CHAIN_LEN=5, WORD_W=8, word 0x1F → 5 shifts of 1, then DONE. start while in SHIFT → ignored, bit_cnt unaffected. start in DONE → restarts and done drops on that edge.

Source files
------------

// File: rtl/config_chain_loader.sv
// Configuration-chain loader: accepts bitstream words and shifts them LSB-first into the
// fabric ccff chain, stopping after exactly CHAIN_LEN bits.
module config_chain_loader #(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned CHAIN_LEN = 1024
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int unsigned WL_W  = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

    state_e            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WL_W-1:0]   word_left;
    logic [WORD_W-1:0] sreg;
    logic              aborted_q;

    logic [31:0]       remaining;
    logic [WL_W-1:0]   word_left_init;
    logic              last_bit;

    // A final word is truncated to the bits still missing from the chain.
    always_comb begin
        remaining      = 32'(CHAIN_LEN) - 32'(bit_cnt);
        word_left_init = (remaining < WORD_W) ? WL_W'(remaining) : WL_W'(WORD_W);
        last_bit       = (32'(bit_cnt) + 32'd1) == 32'(CHAIN_LEN);
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state     <= StIdle;
            bit_cnt   <= '0;
            word_left <= '0;
            sreg      <= '0;
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state   <= StLoad;
                        bit_cnt <= '0;
                    end
                end
                StLoad: begin
                    if (abort) begin
                        state     <= StIdle;
                        aborted_q <= 1'b1;
                    end else if (s_valid) begin
                        sreg      <= s_data;
                        word_left <= word_left_init;
                        state     <= StShift;
                    end
                end
                StShift: begin
                    if (abort) begin
                        state     <= StIdle;
                        aborted_q <= 1'b1;
                    end else begin
                        sreg      <= sreg >> 1;
                        bit_cnt   <= bit_cnt + CNT_W'(1);
                        word_left <= word_left - WL_W'(1);
                        if (word_left == WL_W'(1)) begin
                            state <= last_bit ? StDone : StLoad;
                        end
                    end
                end
                StDone: begin
                    // abort here just clears done; there was no active pass to cancel
                    if (abort) begin
                        state <= StIdle;
                    end else if (start) begin
                        state   <= StLoad;
                        bit_cnt <= '0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign s_ready       = (state == StLoad);
    assign ccff_shift_en = (state == StShift);
    assign ccff_head     = ccff_shift_en & sreg[0];
    assign busy          = (state == StLoad) || (state == StShift);
    assign done          = (state == StDone);
    assign aborted       = aborted_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench for config_chain_loader: WORD_W=8 with CHAIN_LEN=20 and CHAIN_LEN=5.
module tb_config_chain_loader;

    logic       prog_clk = 1'b0;
    logic       pReset;
    logic       start, abort, s_valid;
    logic [7:0] s_data;
    logic       s_ready, ccff_head, ccff_shift_en, busy, done, aborted;
    logic       start2, abort2, s_valid2;
    logic [7:0] s_data2;
    logic       s_ready2, ccff_head2, ccff_shift_en2, busy2, done2, aborted2;

    int n_pass = 0;
    int n_total = 0;

    logic [7:0]  pass_words [3];
    localparam logic [19:0] ExpBits = 20'b1111_0011_1100_1010_0101;

    // {s_ready, ccff_head, ccff_shift_en, busy, done, aborted} after the edge
    typedef struct {
        logic       start;
        logic       abort;
        logic       valid;
        logic [7:0] data;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl [19];

    always #5 prog_clk = ~prog_clk;

    config_chain_loader #(.WORD_W(8), .CHAIN_LEN(20)) dut (
        .prog_clk      (prog_clk),
        .pReset        (pReset),
        .start         (start),
        .abort         (abort),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted)
    );

    config_chain_loader #(.WORD_W(8), .CHAIN_LEN(5)) dut5 (
        .prog_clk      (prog_clk),
        .pReset        (pReset),
        .start         (start2),
        .abort         (abort2),
        .s_data        (s_data2),
        .s_valid       (s_valid2),
        .s_ready       (s_ready2),
        .ccff_head     (ccff_head2),
        .ccff_shift_en (ccff_shift_en2),
        .busy          (busy2),
        .done          (done2),
        .aborted       (aborted2)
    );

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [5:0] outs1();
        return {s_ready, ccff_head, ccff_shift_en, busy, done, aborted};
    endfunction

    function automatic logic [5:0] outs2();
        return {s_ready2, ccff_head2, ccff_shift_en2, busy2, done2, aborted2};
    endfunction

    // Full 20-bit pass with 'stall' idle cycles before each word is offered.
    task automatic run_pass(input int stall, input string tag);
        int         cyc, nbits, accepts, readys, waits;
        logic [19:0] got;
        logic       wait_ok, held;
        cyc = 0; nbits = 0; accepts = 0; readys = 0; waits = 0;
        got = '0; wait_ok = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_ready_after_start"}, 32'(s_ready), 32'd1);
        while (!done && cyc < 200) begin
            held = 1'b0;
            if (s_ready) begin
                readys++;
                if (waits < stall) begin
                    s_valid = 1'b0;
                    waits++;
                    held = 1'b1;
                end else begin
                    s_valid = 1'b1;
                    s_data  = pass_words[accepts % 3];
                    accepts++;
                    waits = 0;
                end
            end else begin
                s_valid = (stall == 0);
            end
            tick();
            cyc++;
            if (held && (!s_ready || ccff_shift_en)) wait_ok = 1'b0;
            if (ccff_shift_en) begin
                if (nbits < 20) got[nbits] = ccff_head;
                nbits++;
            end
        end
        s_valid = 1'b0;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_cycles"}, 32'(cyc), 32'(23 + 3 * stall));
        check({tag, "_bits"}, 32'(got), 32'(ExpBits));
        check({tag, "_nbits"}, 32'(nbits), 32'd20);
        check({tag, "_accepts"}, 32'(accepts), 32'd3);
        check({tag, "_ready_cycles"}, 32'(readys), 32'(3 * (stall + 1)));
        check({tag, "_wait_hold"}, 32'(wait_ok), 32'd1);
    endtask

    initial begin
        int   acc, sh;
        logic idle_ok;
        pass_words[0] = 8'hA5;
        pass_words[1] = 8'h3C;
        pass_words[2] = 8'hFF;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 6'b100100};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 8'h1F, 6'b011100};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 6'b011100};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 6'b011100};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 6'b011100};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 6'b011100};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 6'b000010};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 6'b000010};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 6'b100100};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'h0A, 6'b001100};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 6'b011100};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 6'b001100};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 6'b011100};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 6'b001100};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 6'b000010};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 8'h00, 6'b000000};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 8'h00, 6'b100100};
        tbl[17] = '{1'b0, 1'b1, 1'b1, 8'h55, 6'b000001};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 8'h00, 6'b000000};

        start = 0; abort = 0; s_valid = 0; s_data = '0;
        start2 = 0; abort2 = 0; s_valid2 = 0; s_data2 = '0;

        // Reset, then idle
        pReset = 1'b1;
        tick();
        tick();
        pReset = 1'b0;
        tick();
        check("reset_outputs", 32'(outs1()), 32'd0);
        check("reset_outputs_len5", 32'(outs2()), 32'd0);
        idle_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ccff_head || ccff_shift_en || busy) idle_ok = 1'b0;
        end
        check("idle_quiet", 32'(idle_ok), 32'd1);

        run_pass(0, "basic");
        run_pass(5, "backpressure");

        // Abort on the 4th SHIFT cycle of word 2, starting from DONE
        start = 1'b1;
        tick();
        start = 1'b0;
        acc = 0; sh = 0;
        for (int c = 0; c < 100 && sh < 4; c++) begin
            if (s_ready) begin
                s_valid = 1'b1;
                s_data  = pass_words[acc % 3];
                acc++;
            end
            tick();
            if (ccff_shift_en && acc == 2) sh++;
        end
        check("abort_reached_shift4", 32'(sh), 32'd4);
        s_valid = 1'b0;
        abort   = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_shift_next", 32'(outs1()), 32'b000001);
        tick();
        check("abort_pulse_width", 32'(outs1()), 32'd0);
        run_pass(0, "after_abort");

        // Abort colliding with a valid word in LOAD
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_in_done", 32'(outs1()), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h55;
        abort   = 1'b1;
        tick();
        abort   = 1'b0;
        s_valid = 1'b0;
        check("abort_collide", 32'(outs1()), 32'b000001);
        tick();
        check("abort_collide_idle", 32'(outs1()), 32'd0);

        // Reset mid-SHIFT
        start = 1'b1;
        tick();
        start   = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'hA5;
        tick();
        s_valid = 1'b0;
        tick();
        check("pre_reset_shifting", 32'(ccff_shift_en), 32'd1);
        pReset = 1'b1;
        tick();
        pReset = 1'b0;
        check("reset_mid_shift", 32'(outs1()), 32'd0);

        // CHAIN_LEN=5 instance, table-driven
        for (int i = 0; i < 19; i++) begin
            start2   = tbl[i].start;
            abort2   = tbl[i].abort;
            s_valid2 = tbl[i].valid;
            s_data2  = tbl[i].data;
            tick();
            check($sformatf("len5_row%0d", i), 32'(outs2()), 32'(tbl[i].exp));
        end
        start2 = 0; abort2 = 0; s_valid2 = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
